opb_register_bank_ppc2simulink: RTL

Parametrised bank of C_NUM_REGS 32-bit software registers, written and read back by the PowerPC over OPB and presented to user fabric logic as a flat output vector. It replaces per-register single-word slaves, which each occupy a full OPB decode. It adds:
- byte-enable writes;
- per-register update strobes;
- optional shadow/commit so that multi-word settings (seeds, coefficients) change atomically.

---
 rtl/opb_regbank_pkg.sv | 33 +++
 rtl/opb_slave_ack.sv | 55 +++++
 rtl/opb_register_bank_ppc2simulink.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/opb_regbank_pkg.sv
// Shared definitions for the OPB register bank: slave states, CTRL bits,
// and helpers translating OPB big-endian bit/lane numbering to internal order.
package opb_regbank_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_ACK  = 2'd1;
    localparam logic [1:0] ST_WAIT = 2'd2;

    localparam int CTRL_COMMIT_BIT = 0;

    function automatic int opb_bit(input int k);
        return 31 - k;
    endfunction

    function automatic int opb_lane(input int j);
        return 3 - j;
    endfunction

    // be[b] guards internal byte b (bits 8*b+7 .. 8*b)
    function automatic logic [31:0] be_merge(
        input logic [31:0] old,
        input logic [31:0] d,
        input logic [3:0]  be
    );
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) begin
            if (be[b]) r[8*b +: 8] = d[8*b +: 8];
        end
        return r;
    endfunction

endpackage

// File: rtl/opb_slave_ack.sv
// OPB address decode and IDLE/ACK/WAIT handshake; emits a one-cycle
// hit strobe with word index so each transfer is acked exactly once.
module opb_slave_ack
    import opb_regbank_pkg::*;
#(
    parameter logic [31:0] C_BASEADDR   = 32'h01060D00,
    parameter logic [31:0] C_HIGHADDR   = 32'h01060DFF,
    parameter int          C_OPB_AWIDTH = 32
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    select,
    input  logic                    rnw,
    input  logic [C_OPB_AWIDTH-1:0] addr,
    output logic                    strobe,
    output logic [C_OPB_AWIDTH-3:0] idx,
    output logic                    is_read,
    output logic                    ack
);

    localparam int AW = C_OPB_AWIDTH;

    logic [1:0]    state;
    logic [1:0]    nxt;
    logic          hit;
    logic [AW-1:0] offset;
    logic [1:0]    unused_lsb;

    assign hit = select
              && (addr >= AW'(C_BASEADDR))
              && (addr <= AW'(C_HIGHADDR));

    assign offset     = addr - AW'(C_BASEADDR);
    assign idx        = offset[AW-1:2];
    assign unused_lsb = offset[1:0];
    assign is_read    = rnw;
    assign strobe     = (state == ST_IDLE) && hit;
    assign ack        = (state == ST_ACK);

    always_comb begin
        nxt = state;
        unique case (state)
            ST_IDLE: if (hit) nxt = ST_ACK;
            ST_ACK:  nxt = ST_WAIT;
            ST_WAIT: if (!select) nxt = ST_IDLE;
            default: nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= nxt;
    end

endmodule

// File: rtl/opb_register_bank_ppc2simulink.sv
// Bank of 32-bit software registers on OPB with byte-enable writes and update strobes.
// Define OPB_REGBANK_SHADOW_EN for shadow registers with atomic CTRL commit.
module opb_register_bank_ppc2simulink
    import opb_regbank_pkg::*;
#(
    parameter logic [31:0] C_BASEADDR   = 32'h01060D00,
    parameter logic [31:0] C_HIGHADDR   = 32'h01060DFF,
    parameter int          C_NUM_REGS   = 8,
    parameter int          C_OPB_AWIDTH = 32,
    parameter int          C_OPB_DWIDTH = 32,
    parameter string       C_FAMILY     = "virtex5"
) (
    input  logic                      OPB_Clk,
    input  logic                      OPB_Rst_n,
    input  logic [0:C_OPB_AWIDTH-1]   OPB_ABus,
    input  logic [0:3]                OPB_BE,
    input  logic [0:C_OPB_DWIDTH-1]   OPB_DBus,
    input  logic                      OPB_RNW,
    input  logic                      OPB_select,
    input  logic                      OPB_seqAddr,
    output logic [0:C_OPB_DWIDTH-1]   Sl_DBus,
    output logic                      Sl_xferAck,
    output logic                      Sl_errAck,
    output logic                      Sl_retry,
    output logic                      Sl_toutSup,
    output logic [32*C_NUM_REGS-1:0]  user_data_out,
    output logic [C_NUM_REGS-1:0]     user_data_valid
);

    localparam int    IW            = C_OPB_AWIDTH - 2;
    localparam string unused_family = C_FAMILY;

    logic                     unused_seq;
    logic                     strobe;
    logic                     is_read;
    logic [IW-1:0]            idx;
    logic [31:0]              wdata;
    logic [3:0]               be;
    logic [31:0]              rd_mux;
    logic [31:0]              rd_q;
    logic [31:0]              ctrl_rd;
    logic [C_NUM_REGS-1:0]    wr_hit;
    logic [32*C_NUM_REGS-1:0] store;

    assign unused_seq = OPB_seqAddr;
    assign Sl_errAck  = 1'b0;
    assign Sl_retry   = 1'b0;
    assign Sl_toutSup = 1'b0;

    opb_slave_ack #(
        .C_BASEADDR   (C_BASEADDR),
        .C_HIGHADDR   (C_HIGHADDR),
        .C_OPB_AWIDTH (C_OPB_AWIDTH)
    ) u_ack (
        .clk     (OPB_Clk),
        .rst_n   (OPB_Rst_n),
        .select  (OPB_select),
        .rnw     (OPB_RNW),
        .addr    (OPB_ABus),
        .strobe  (strobe),
        .idx     (idx),
        .is_read (is_read),
        .ack     (Sl_xferAck)
    );

    always_comb begin
        wdata   = '0;
        be      = '0;
        Sl_DBus = '0;
        for (int k = 0; k < 32; k++) begin
            wdata[opb_bit(k)] = OPB_DBus[k];
            Sl_DBus[k]        = rd_q[opb_bit(k)];
        end
        for (int j = 0; j < 4; j++) be[opb_lane(j)] = OPB_BE[j];
    end

    always_comb begin
        wr_hit = '0;
        for (int i = 0; i < C_NUM_REGS; i++) begin
            wr_hit[i] = strobe && !is_read && (idx == IW'(i));
        end
    end

`ifdef OPB_REGBANK_SHADOW_EN
    logic [32*C_NUM_REGS-1:0] shadow;
    logic [C_NUM_REGS-1:0]    pending;
    logic                     commit;

    assign commit = strobe && !is_read
                 && (idx == IW'(C_NUM_REGS))
                 && be[CTRL_COMMIT_BIT/8]
                 && wdata[CTRL_COMMIT_BIT];
    assign store   = shadow;
    assign ctrl_rd = 32'(pending);

    always_ff @(posedge OPB_Clk or negedge OPB_Rst_n) begin
        if (!OPB_Rst_n) begin
            shadow          <= '0;
            pending         <= '0;
            user_data_out   <= '0;
            user_data_valid <= '0;
        end else begin
            user_data_valid <= '0;
            for (int i = 0; i < C_NUM_REGS; i++) begin
                if (wr_hit[i]) begin
                    shadow[32*i +: 32] <= be_merge(shadow[32*i +: 32], wdata, be);
                    pending[i]         <= 1'b1;
                end
            end
            // All slices move on one edge so multi-word settings stay coherent
            if (commit) begin
                user_data_out   <= shadow;
                user_data_valid <= pending;
                pending         <= '0;
            end
        end
    end
`else
    assign store   = user_data_out;
    assign ctrl_rd = '0;

    always_ff @(posedge OPB_Clk or negedge OPB_Rst_n) begin
        if (!OPB_Rst_n) begin
            user_data_out   <= '0;
            user_data_valid <= '0;
        end else begin
            user_data_valid <= wr_hit;
            for (int i = 0; i < C_NUM_REGS; i++) begin
                if (wr_hit[i]) begin
                    user_data_out[32*i +: 32] <=
                        be_merge(user_data_out[32*i +: 32], wdata, be);
                end
            end
        end
    end
`endif

    always_comb begin
        rd_mux = '0;
        for (int i = 0; i < C_NUM_REGS; i++) begin
            if (idx == IW'(i)) rd_mux = store[32*i +: 32];
        end
        if (idx == IW'(C_NUM_REGS)) rd_mux = ctrl_rd;
    end

    // Read data lives only in the ack cycle; the bus sees zero otherwise
    always_ff @(posedge OPB_Clk or negedge OPB_Rst_n) begin
        if (!OPB_Rst_n)               rd_q <= '0;
        else if (strobe && is_read)   rd_q <= rd_mux;
        else                          rd_q <= '0;
    end

endmodule
